// File: rtl/ifdef_nest_ctrl.sv
// ifdef_nest_ctrl: conditional-compilation controller.
// Consumes classified directive tokens and tracks `ifdef nesting on a small stack.
// Drives emit_en to gate downstream text emission.
// Structural errors are latched and the block halts until err_clr.
module ifdef_nest_ctrl #(
  parameter int MAX_DEPTH = 8,
  localparam int DW = $clog2(MAX_DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tok_valid,
  output logic          tok_ready,
  input  logic [2:0]    tok_op,
  input  logic          tok_defined,
  input  logic          err_clr,
  output logic          emit_en,
  output logic [DW-1:0] depth,
  output logic [2:0]    err_code,
  output logic          done,
  output logic [15:0]   skip_cnt
);

  // Stack index width; the stack is rounded up to a power of two so any index is legal
  localparam int AW = (MAX_DEPTH > 1) ? $clog2(MAX_DEPTH) : 1;
  localparam int SD = 1 << AW;
  localparam logic [DW-1:0] DEPTH_MAX  = DW'(MAX_DEPTH);
  localparam logic [DW-1:0] DEPTH_ZERO = '0;

  localparam logic [2:0] ERR_NONE      = 3'd0;
  localparam logic [2:0] ERR_OVERFLOW  = 3'd1;
  localparam logic [2:0] ERR_UNDERFLOW = 3'd2;
  localparam logic [2:0] ERR_ORDER     = 3'd3;
  localparam logic [2:0] ERR_UNCLOSED  = 3'd4;

  typedef enum logic {
    ST_RUN,
    ST_HALT
  } state_e;

  typedef enum logic [2:0] {
    OP_TEXT   = 3'd0,
    OP_IFDEF  = 3'd1,
    OP_IFNDEF = 3'd2,
    OP_ELSIF  = 3'd3,
    OP_ELSE   = 3'd4,
    OP_ENDIF  = 3'd5,
    OP_EOF    = 3'd6,
    OP_RSVD   = 3'd7
  } op_e;

  state_e        state_q, state_d;
  logic          active_q, active_d;
  logic [DW-1:0] depth_q, depth_d;
  logic [2:0]    err_q, err_d;
  logic          done_q, done_d;
  logic [15:0]   skip_q;

  logic          accept;
  op_e           op;
  logic          cond;
  logic [2:0]    err_det;
  logic          skip_inc;
  logic          push_en;
  logic          top_wr;
  logic          top_taken_d;
  logic          top_in_else_d;

  logic          stk_parent  [SD];
  logic          stk_taken   [SD];
  logic          stk_in_else [SD];

  logic [AW-1:0] top_idx;
  logic [AW-1:0] push_idx;
  logic          top_parent;
  logic          top_taken;
  logic          top_in_else;

  assign op          = op_e'(tok_op);
  assign tok_ready   = (state_q == ST_RUN);
  assign accept      = tok_valid & tok_ready;
  assign top_idx     = AW'(depth_q - 1'b1);
  assign push_idx    = AW'(depth_q);
  assign top_parent  = stk_parent[top_idx];
  assign top_taken   = stk_taken[top_idx];
  assign top_in_else = stk_in_else[top_idx];

  assign emit_en  = active_q;
  assign depth    = depth_q;
  assign err_code = err_q;
  assign done     = done_q;
  assign skip_cnt = skip_q;

  // Next-state logic: decode the accepted token, detect errors, and plan stack updates
  always_comb begin
    state_d       = state_q;
    active_d      = active_q;
    depth_d       = depth_q;
    err_d         = err_q;
    done_d        = 1'b0;
    skip_inc      = 1'b0;
    push_en       = 1'b0;
    top_wr        = 1'b0;
    top_taken_d   = top_taken;
    top_in_else_d = top_in_else;
    err_det       = ERR_NONE;
    cond          = tok_defined ^ (op == OP_IFNDEF);

    case (state_q)
      ST_RUN: begin
        if (accept) begin
          case (op)
            OP_IFDEF, OP_IFNDEF: begin
              if (depth_q == DEPTH_MAX) begin
                err_det = ERR_OVERFLOW;
              end else begin
                push_en  = 1'b1;
                active_d = active_q & cond;
                depth_d  = depth_q + 1'b1;
              end
            end
            OP_ELSIF: begin
              if (depth_q == DEPTH_ZERO) begin
                err_det = ERR_UNDERFLOW;
              end else if (top_in_else) begin
                err_det = ERR_ORDER;
              end else if (top_taken) begin
                active_d = 1'b0;
              end else begin
                active_d    = top_parent & tok_defined;
                top_wr      = 1'b1;
                top_taken_d = tok_defined;
              end
            end
            OP_ELSE: begin
              if (depth_q == DEPTH_ZERO) begin
                err_det = ERR_UNDERFLOW;
              end else if (top_in_else) begin
                err_det = ERR_ORDER;
              end else begin
                active_d      = top_parent & ~top_taken;
                top_wr        = 1'b1;
                top_taken_d   = 1'b1;
                top_in_else_d = 1'b1;
              end
            end
            OP_ENDIF: begin
              if (depth_q == DEPTH_ZERO) begin
                err_det = ERR_UNDERFLOW;
              end else begin
                active_d = top_parent;
                depth_d  = depth_q - 1'b1;
              end
            end
            OP_EOF: begin
              if (depth_q != DEPTH_ZERO) begin
                err_det = ERR_UNCLOSED;
              end else begin
                done_d = 1'b1;
              end
            end
            default: begin
              skip_inc = ~active_q;
            end
          endcase

          if (err_det != ERR_NONE) begin
            state_d  = ST_HALT;
            err_d    = err_det;
            active_d = 1'b0;
          end
        end
      end

      ST_HALT: begin
        if (err_clr) begin
          state_d  = ST_RUN;
          depth_d  = DEPTH_ZERO;
          active_d = 1'b1;
          err_d    = ERR_NONE;
        end
      end

      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Region, depth, error and status registers; skip counter saturates rather than wrapping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active_q <= 1'b1;
      depth_q  <= DEPTH_ZERO;
      err_q    <= ERR_NONE;
      done_q   <= 1'b0;
      skip_q   <= 16'h0000;
    end else begin
      active_q <= active_d;
      depth_q  <= depth_d;
      err_q    <= err_d;
      done_q   <= done_d;
      if (skip_inc && (skip_q != 16'hFFFF)) begin
        skip_q <= skip_q + 16'h0001;
      end
    end
  end

  // Nesting stack storage; entries above depth are never read, so no reset is needed
  always_ff @(posedge clk) begin
    if (push_en) begin
      stk_parent[push_idx]  <= active_q;
      stk_taken[push_idx]   <= cond;
      stk_in_else[push_idx] <= 1'b0;
    end
    if (top_wr) begin
      stk_taken[top_idx]   <= top_taken_d;
      stk_in_else[top_idx] <= top_in_else_d;
    end
  end

endmodule

// File: tb/tb_ifdef_nest_ctrl.sv
// tb_ifdef_nest_ctrl: directed self-checking bench for ifdef_nest_ctrl.
// Expected values are hand-computed from the token semantics.
module tb_ifdef_nest_ctrl;

  localparam int MAX_DEPTH = 8;
  localparam int DW = $clog2(MAX_DEPTH + 1);

  localparam logic [2:0] TEXT   = 3'd0;
  localparam logic [2:0] IFDEF  = 3'd1;
  localparam logic [2:0] IFNDEF = 3'd2;
  localparam logic [2:0] ELSIF  = 3'd3;
  localparam logic [2:0] ELSE   = 3'd4;
  localparam logic [2:0] ENDIF  = 3'd5;
  localparam logic [2:0] EOF    = 3'd6;
  localparam logic [2:0] RSVD   = 3'd7;

  logic          clk;
  logic          rst;
  logic          tok_valid;
  logic          tok_ready;
  logic [2:0]    tok_op;
  logic          tok_defined;
  logic          err_clr;
  logic          emit_en;
  logic [DW-1:0] depth;
  logic [2:0]    err_code;
  logic          done;
  logic [15:0]   skip_cnt;

  int num_checks;
  int num_fails;

  ifdef_nest_ctrl #(.MAX_DEPTH(MAX_DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .tok_valid   (tok_valid),
    .tok_ready   (tok_ready),
    .tok_op      (tok_op),
    .tok_defined (tok_defined),
    .err_clr     (err_clr),
    .emit_en     (emit_en),
    .depth       (depth),
    .err_code    (err_code),
    .done        (done),
    .skip_cnt    (skip_cnt)
  );

  // Free-running 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Compare one observed value against its expected value and tally the result
  task automatic checkOutput(input string tag, input int actual, input int expected);
    num_checks++;
    if (actual !== expected) begin
      num_fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // Present one token for a single clock edge; returns 1 ns after that edge
  task automatic applyStimulus(input logic [2:0] op, input logic def);
    @(negedge clk);
    tok_valid   = 1'b1;
    tok_op      = op;
    tok_defined = def;
    @(posedge clk);
    #1;
    tok_valid = 1'b0;
  endtask

  // Pulse err_clr for one edge, optionally with a token offered at the same time
  task automatic clearError(input logic with_tok);
    @(negedge clk);
    err_clr     = 1'b1;
    tok_valid   = with_tok;
    tok_op      = IFDEF;
    tok_defined = 1'b1;
    @(posedge clk);
    #1;
    err_clr   = 1'b0;
    tok_valid = 1'b0;
  endtask

  // Check the full reset-value set of outputs
  task automatic checkResetValues(input string tag);
    checkOutput({tag, " tok_ready"}, int'(tok_ready), 1);
    checkOutput({tag, " emit_en"},   int'(emit_en),   1);
    checkOutput({tag, " depth"},     int'(depth),     0);
    checkOutput({tag, " err_code"},  int'(err_code),  0);
    checkOutput({tag, " done"},      int'(done),      0);
    checkOutput({tag, " skip_cnt"},  int'(skip_cnt),  0);
  endtask

  // Directed scenario sequence
  initial begin
    num_checks  = 0;
    num_fails   = 0;
    rst         = 1'b1;
    tok_valid   = 1'b0;
    tok_op      = TEXT;
    tok_defined = 1'b0;
    err_clr     = 1'b0;

    #12;
    checkResetValues("rst_held");
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkResetValues("rst_released");

    // if / else with text in both branches
    applyStimulus(IFDEF, 1'b1);
    checkOutput("t1 ifdef emit", int'(emit_en), 1);
    checkOutput("t1 ifdef depth", int'(depth), 1);
    applyStimulus(TEXT, 1'b0);
    checkOutput("t1 text emit", int'(emit_en), 1);
    checkOutput("t1 text skip", int'(skip_cnt), 0);
    applyStimulus(ELSE, 1'b0);
    checkOutput("t1 else emit", int'(emit_en), 0);
    checkOutput("t1 else depth", int'(depth), 1);
    applyStimulus(TEXT, 1'b0);
    checkOutput("t1 text2 emit", int'(emit_en), 0);
    checkOutput("t1 text2 skip", int'(skip_cnt), 1);
    applyStimulus(ENDIF, 1'b0);
    checkOutput("t1 endif emit", int'(emit_en), 1);
    checkOutput("t1 endif depth", int'(depth), 0);
    applyStimulus(RSVD, 1'b0);
    checkOutput("t1 rsvd active skip", int'(skip_cnt), 1);

    // elsif chain: only the first true branch is taken
    applyStimulus(IFDEF, 1'b0);
    checkOutput("t2 ifdef0 emit", int'(emit_en), 0);
    applyStimulus(ELSIF, 1'b0);
    checkOutput("t2 elsif0 emit", int'(emit_en), 0);
    applyStimulus(ELSIF, 1'b1);
    checkOutput("t2 elsif1 emit", int'(emit_en), 1);
    applyStimulus(ELSIF, 1'b1);
    checkOutput("t2 elsif1b emit", int'(emit_en), 0);
    applyStimulus(ELSE, 1'b0);
    checkOutput("t2 else emit", int'(emit_en), 0);
    applyStimulus(ENDIF, 1'b0);
    checkOutput("t2 endif emit", int'(emit_en), 1);
    checkOutput("t2 endif depth", int'(depth), 0);

    // Nested: inactive parent keeps the inner else inactive
    applyStimulus(IFDEF, 1'b0);
    applyStimulus(IFDEF, 1'b1);
    checkOutput("t3 inner emit", int'(emit_en), 0);
    checkOutput("t3 inner depth", int'(depth), 2);
    applyStimulus(ELSE, 1'b0);
    checkOutput("t3 inner else emit", int'(emit_en), 0);
    applyStimulus(ENDIF, 1'b0);
    checkOutput("t3 endif1 emit", int'(emit_en), 0);
    applyStimulus(ENDIF, 1'b0);
    checkOutput("t3 endif2 emit", int'(emit_en), 1);
    checkOutput("t3 endif2 depth", int'(depth), 0);

    // ifndef inverts the condition
    applyStimulus(IFNDEF, 1'b1);
    checkOutput("t3 ifndef1 emit", int'(emit_en), 0);
    applyStimulus(ELSE, 1'b0);
    checkOutput("t3 ifndef else emit", int'(emit_en), 1);
    applyStimulus(ENDIF, 1'b0);

    // Overflow on the ninth push
    for (int i = 0; i < 9; i++) applyStimulus(IFDEF, 1'b1);
    checkOutput("t4 ovf err", int'(err_code), 1);
    checkOutput("t4 ovf ready", int'(tok_ready), 0);
    checkOutput("t4 ovf depth", int'(depth), 8);
    checkOutput("t4 ovf emit", int'(emit_en), 0);
    applyStimulus(ENDIF, 1'b0);
    checkOutput("t4 halt ignores tok depth", int'(depth), 8);
    checkOutput("t4 halt err held", int'(err_code), 1);
    clearError(1'b0);
    checkOutput("t4 clr depth", int'(depth), 0);
    checkOutput("t4 clr emit", int'(emit_en), 1);
    checkOutput("t4 clr ready", int'(tok_ready), 1);
    checkOutput("t4 clr err", int'(err_code), 0);
    checkOutput("t4 clr keeps skip", int'(skip_cnt), 1);
    clearError(1'b0);
    checkOutput("t4 clr in run depth", int'(depth), 0);

    // Underflow on endif at depth 0
    applyStimulus(ENDIF, 1'b0);
    checkOutput("t5 underflow err", int'(err_code), 2);
    checkOutput("t5 underflow ready", int'(tok_ready), 0);
    clearError(1'b0);

    // Order error on a second else; clear with a token offered that must be dropped
    applyStimulus(IFDEF, 1'b1);
    applyStimulus(ELSE, 1'b0);
    applyStimulus(ELSE, 1'b0);
    checkOutput("t5 order err", int'(err_code), 3);
    checkOutput("t5 order emit", int'(emit_en), 0);
    clearError(1'b1);
    checkOutput("t5 clr with tok depth", int'(depth), 0);
    checkOutput("t5 clr with tok emit", int'(emit_en), 1);

    // Elsif at depth 0 reports underflow, not order
    applyStimulus(ELSIF, 1'b1);
    checkOutput("t5 elsif depth0 err", int'(err_code), 2);
    clearError(1'b0);

    // Elsif after else is an order error
    applyStimulus(IFDEF, 1'b0);
    applyStimulus(ELSE, 1'b0);
    applyStimulus(ELSIF, 1'b1);
    checkOutput("t5 elsif after else err", int'(err_code), 3);
    clearError(1'b0);

    // Unclosed region at EOF
    applyStimulus(IFDEF, 1'b1);
    applyStimulus(EOF, 1'b0);
    checkOutput("t5 unclosed err", int'(err_code), 4);
    checkOutput("t5 unclosed done", int'(done), 0);
    clearError(1'b0);

    // Clean EOF pulses done for exactly one cycle
    applyStimulus(EOF, 1'b0);
    checkOutput("t5 eof done", int'(done), 1);
    checkOutput("t5 eof err", int'(err_code), 0);
    checkOutput("t5 eof ready", int'(tok_ready), 1);
    @(posedge clk);
    #1;
    checkOutput("t5 eof done drop", int'(done), 0);

    // Back-to-back pushes, then asynchronous reset mid-stream at depth 3
    applyStimulus(IFDEF, 1'b1);
    applyStimulus(IFDEF, 1'b0);
    applyStimulus(IFDEF, 1'b1);
    checkOutput("t6 pre-rst depth", int'(depth), 3);
    checkOutput("t6 pre-rst emit", int'(emit_en), 0);
    tok_valid = 1'b1;
    tok_op    = ENDIF;
    #1;
    rst = 1'b1;
    #1;
    checkResetValues("t6 async rst");
    @(negedge clk);
    rst       = 1'b0;
    tok_valid = 1'b0;

    // Saturating skip counter over 70000 inactive text tokens
    applyStimulus(IFDEF, 1'b0);
    @(negedge clk);
    tok_valid = 1'b1;
    tok_op    = TEXT;
    repeat (65534) @(posedge clk);
    #1;
    checkOutput("t6 skip below sat", int'(skip_cnt), 32'hFFFE);
    repeat (70000 - 65534) @(posedge clk);
    #1;
    tok_valid = 1'b0;
    checkOutput("t6 skip saturated", int'(skip_cnt), 32'hFFFF);
    checkOutput("t6 skip emit", int'(emit_en), 0);
    checkOutput("t6 skip depth", int'(depth), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
    $finish;
  end

endmodule
